// File: rtl/sn76489_sequencer_wb8_pkg.sv
// sn76489_sequencer_wb8_pkg: shared entry types, status bit positions and FSM encodings for the PSG sequencer
package sn76489_sequencer_wb8_pkg;
  localparam logic SEQ_TYPE_PSG  = 1'b0;
  localparam logic SEQ_TYPE_WAIT = 1'b1;
  localparam int ST_OVF   = 7;
  localparam int ST_BUSY  = 6;
  localparam int ST_FULL  = 5;
  localparam int ST_EMPTY = 4;
  typedef enum logic [1:0] {IDLE, PSG_STB, PSG_ACK, WAIT} seq_state_e;
  typedef struct packed {
    logic       typ;
    logic [7:0] dat;
  } seq_entry_t;
endpackage

// File: rtl/sn76489_seq_fifo.sv
// sn76489_seq_fifo: synchronous FIFO of 2**FIFO_DEPTH_LOG2 entries; pushes while full and pops while empty are ignored
module sn76489_seq_fifo #(
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int W = 9
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [FIFO_DEPTH_LOG2:0] count_o
);
  localparam int D = 1 << FIFO_DEPTH_LOG2;
  logic [W-1:0] mem_q [D];
  logic [FIFO_DEPTH_LOG2-1:0] wr_q, rd_q;
  logic [FIFO_DEPTH_LOG2:0] cnt_q;
  logic do_push, do_pop;
  assign full_o  = cnt_q == (FIFO_DEPTH_LOG2+1)'(D);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  // pointer and occupancy bookkeeping; pointers wrap naturally at the depth
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + FIFO_DEPTH_LOG2'(do_push);
      rd_q  <= rd_q + FIFO_DEPTH_LOG2'(do_pop);
      cnt_q <= cnt_q + (FIFO_DEPTH_LOG2+1)'(do_push) - (FIFO_DEPTH_LOG2+1)'(do_pop);
    end
  end
  // entry storage needs no reset: occupancy alone says what is valid
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/sn76489_sequencer_wb8.sv
// sn76489_sequencer_wb8: Wishbone-fed FIFO of PSG bytes and tick waits replayed to the PSG; optional O_irq via SN76489_SEQ_IRQ_EN
module sn76489_sequencer_wb8
  import sn76489_sequencer_wb8_pkg::*;
#(
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int TICKDIVIDE = 2268
) (
  input  logic       I_wb_clk,
  input  logic       I_reset,
  input  logic       I_wb_adr,
  input  logic [7:0] I_wb_dat,
  input  logic       I_wb_stb,
  input  logic       I_wb_we,
  output logic       O_wb_ack,
  output logic [7:0] O_wb_dat,
  output logic       O_psg_stb,
  output logic       O_psg_we,
  output logic [7:0] O_psg_dat,
  input  logic       I_psg_ack,
  output logic       O_irq
);
  localparam int PW = $clog2(TICKDIVIDE);
  seq_state_e state_q, state_d;
  seq_entry_t head;
  logic ack_q, hold_q, ovf_q, ovf_d;
  logic [7:0] rdat_q, rdat_d, byte_q, byte_d, wcnt_q, wcnt_d, status;
  logic [PW-1:0] pre_q, pre_d;
  logic [FIFO_DEPTH_LOG2:0] cnt;
  logic full, empty, accept, push, rd, pop, busy, tick;
  assign accept   = I_wb_stb && !ack_q && !hold_q;
  assign push     = accept && I_wb_we;
  assign rd       = accept && !I_wb_we;
  assign busy     = state_q != IDLE;
  assign pop      = !busy && !empty;
  assign tick     = pre_q == '0;
  assign O_wb_ack = ack_q;
  assign O_wb_dat = rdat_q;
  sn76489_seq_fifo #(.FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2), .W(9)) u_fifo (
    .clk_i(I_wb_clk),
    .rst_i(I_reset),
    .push_i(push),
    .pop_i(pop),
    .din_i({I_wb_adr, I_wb_dat}),
    .dout_o(head),
    .full_o(full),
    .empty_o(empty),
    .count_o(cnt)
  );
  // status snapshot and sticky overflow; a same-cycle set beats the adr-1 read clear
  always_comb begin
    status           = '0;
    status[ST_OVF]   = ovf_q;
    status[ST_BUSY]  = busy;
    status[ST_FULL]  = full;
    status[ST_EMPTY] = empty;
    status[3:0]      = int'(cnt) > 15 ? 4'hF : 4'(cnt);
    ovf_d            = (push && full) || (ovf_q && !(rd && I_wb_adr));
    rdat_d           = rd ? status : rdat_q;
  end
  // slave handshake: a strobe held past its ack is not re-accepted until it drops
  always_ff @(posedge I_wb_clk) begin
    if (I_reset) begin
      ack_q  <= 1'b0;
      hold_q <= 1'b0;
      ovf_q  <= 1'b0;
      rdat_q <= '0;
    end else begin
      ack_q  <= accept;
      hold_q <= I_wb_stb && (accept || hold_q);
      ovf_q  <= ovf_d;
      rdat_q <= rdat_d;
    end
  end
  // sequencer state, holding register, wait counter and tick prescaler
  always_ff @(posedge I_wb_clk) begin
    if (I_reset) begin
      state_q <= IDLE;
      byte_q  <= '0;
      wcnt_q  <= '0;
      pre_q   <= '0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      wcnt_q  <= wcnt_d;
      pre_q   <= pre_d;
    end
  end
  // next state: pop in IDLE, one-cycle strobe, wait for ack, or count (dat+1)*TICKDIVIDE cycles
  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    wcnt_d  = wcnt_q;
    pre_d   = pre_q;
    case (state_q)
      IDLE: if (pop) begin
        state_d = head.typ == SEQ_TYPE_WAIT ? WAIT : PSG_STB;
        byte_d  = head.typ == SEQ_TYPE_PSG ? head.dat : byte_q;
        wcnt_d  = head.dat;
        pre_d   = PW'(TICKDIVIDE - 1);
      end
      PSG_STB: state_d = PSG_ACK;
      PSG_ACK: state_d = I_psg_ack ? IDLE : PSG_ACK;
      WAIT: begin
        pre_d   = tick ? PW'(TICKDIVIDE - 1) : pre_q - 1'b1;
        wcnt_d  = tick && wcnt_q != '0 ? wcnt_q - 1'b1 : wcnt_q;
        state_d = tick && wcnt_q == '0 ? IDLE : WAIT;
      end
      default: state_d = IDLE;
    endcase
  end
  // master outputs decoded from state; the byte stays on the bus until the next PSG entry
  always_comb begin
    O_psg_stb = state_q == PSG_STB;
    O_psg_we  = state_q == PSG_STB;
    O_psg_dat = byte_q;
  end
`ifdef SN76489_SEQ_IRQ_EN
  logic irq_q;
  // level interrupt while the FIFO is below half full
  always_ff @(posedge I_wb_clk) begin
    if (I_reset) irq_q <= 1'b0;
    else irq_q <= int'(cnt) < (1 << (FIFO_DEPTH_LOG2 - 1)) && (busy || cnt != '0 || !ovf_q);
  end
  assign O_irq = irq_q;
`else
  assign O_irq = 1'b0;
`endif
endmodule

// File: tb/tb_sn76489_sequencer_wb8.sv
// tb_sn76489_sequencer_wb8: scoreboard bench for the PSG sequencer (small FIFO, short tick)
module tb_sn76489_sequencer_wb8;
  localparam int L = 2;
  localparam int TD = 4;
`ifdef SN76489_SEQ_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif
  typedef struct {
    logic [7:0] b;
    int gap;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, adr = 1'b0, stb = 1'b0, we = 1'b0, psg_ack = 1'b0;
  logic [7:0] dat = '0, o_dat, o_psg_dat, s;
  logic o_ack, o_stb, o_we, o_irq;
  exp_t sb[$];
  int total = 0, bad = 0, cyc = 0, last_stb = 0, acks;
  logic ack_en = 1'b1, pend = 1'b0, stb_prev = 1'b0;
  sn76489_sequencer_wb8 #(.FIFO_DEPTH_LOG2(L), .TICKDIVIDE(TD)) dut (
    .I_wb_clk(clk),
    .I_reset(rst),
    .I_wb_adr(adr),
    .I_wb_dat(dat),
    .I_wb_stb(stb),
    .I_wb_we(we),
    .O_wb_ack(o_ack),
    .O_wb_dat(o_dat),
    .O_psg_stb(o_stb),
    .O_psg_we(o_we),
    .O_psg_dat(o_psg_dat),
    .I_psg_ack(psg_ack),
    .O_irq(o_irq)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // PSG model: acks one cycle after the strobe cycle, held off while ack_en is low
  always @(posedge clk) begin
    psg_ack <= 1'b0;
    if (rst) pend <= 1'b0;
    else if (o_stb) pend <= 1'b1;
    else if (pend && ack_en) begin
      psg_ack <= 1'b1;
      pend <= 1'b0;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && o_stb) begin
      chk("stb_1cyc", 32'(stb_prev), 0);
      chk("psg_we", 32'(o_we), 1);
      chk("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("psg_dat", 32'(o_psg_dat), 32'(e.b));
        if (e.gap != 0) chk("stb_gap", cyc - last_stb, e.gap);
      end
      last_stb = cyc;
    end
    stb_prev = o_stb;
  end
  task automatic wb_wr(input logic a, input logic [7:0] d);
    @(negedge clk);
    adr = a; dat = d; we = 1'b1; stb = 1'b1;
    @(negedge clk);
    stb = 1'b0; we = 1'b0;
    chk("wr_ack", 32'(o_ack), 1);
  endtask
  task automatic wb_rd(input logic a, output logic [7:0] d);
    @(negedge clk);
    adr = a; we = 1'b0; stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    chk("rd_ack", 32'(o_ack), 1);
    d = o_dat;
  endtask
  task automatic psg(input logic [7:0] b, input int gap);
    sb.push_back('{b, gap});
    wb_wr(1'b0, b);
  endtask
  task automatic wait_idle(input string tag);
    logic [7:0] r;
    int n = 0;
    do begin
      wb_rd(1'b0, r);
      n++;
    end while (r != 8'h10 && n < 400);
    chk(tag, 32'(r), 32'h10);
    chk("sb_drained", sb.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_psg_stb", 32'(o_stb), 0);
    chk("rst_wb_ack", 32'(o_ack), 0);
    chk("rst_psg_dat", 32'(o_psg_dat), 0);
    chk("rst_irq", 32'(o_irq), 0);
    rst = 1'b0;
    wb_rd(1'b0, s);
    chk("status_rst", 32'(s), 32'h10);
    repeat (4) @(negedge clk);
    chk("irq_idle", 32'(o_irq), 32'(IRQ_ON));
    psg(8'h9F, 0);
    psg(8'hBF, 4);
    wait_idle("idle_b2b");
    psg(8'h80, 0);
    sb.push_back('{8'h05, 5 + 3 * TD});
    wb_wr(1'b1, 8'h02);
    wb_wr(1'b0, 8'h05);
    wait_idle("idle_wait");
    ack_en = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      if (i <= 5) sb.push_back('{8'(8'h40 + i), 0});
      wb_wr(1'b0, 8'(8'h40 + i));
    end
    wb_rd(1'b0, s);
    chk("status_ovf", 32'(s), 32'hE4);
    wb_rd(1'b1, s);
    chk("status_ovf_clr_rd", 32'(s), 32'hE4);
    wb_rd(1'b0, s);
    chk("status_after_clr", 32'(s), 32'h64);
    ack_en = 1'b1;
    wait_idle("idle_ovf");
    sb.push_back('{8'h33, 0});
    acks = 0;
    @(negedge clk);
    adr = 1'b0; dat = 8'h33; we = 1'b1; stb = 1'b1;
    repeat (3) begin
      @(negedge clk);
      acks += int'(o_ack);
    end
    stb = 1'b0; we = 1'b0;
    repeat (3) begin
      @(negedge clk);
      acks += int'(o_ack);
    end
    chk("held_acks", acks, 1);
    wait_idle("idle_held");
    psg(8'h11, 0);
    wb_wr(1'b1, 8'hFF);
    wb_wr(1'b0, 8'h22);
    wb_wr(1'b0, 8'h33);
    wb_wr(1'b0, 8'h44);
    wb_rd(1'b0, s);
    chk("status_in_wait", 32'(s), 32'h43);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wb_rd(1'b0, s);
    chk("status_after_rst", 32'(s), 32'h10);
    repeat (60) @(negedge clk);
    ack_en = 1'b0;
    for (int i = 0; i < 5; i++) psg(8'(8'hC0 + i), 0);
    repeat (2) @(negedge clk);
    chk("irq_full", 32'(o_irq), 0);
    ack_en = 1'b1;
    wait_idle("idle_drain");
    chk("irq_drain", 32'(o_irq), 32'(IRQ_ON));
    chk("sb_final", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
